// File: rtl/controle_medida_hcsr04.sv
// Control unit sequencing the HC-SR04 interface datapath: single-shot and
// continuous measurements, with a timeout that aborts a measurement whose echo
// never completes.
// Optional build macro HCSR04_RETRY_EN: the first timeout of a measurement
// retriggers once before the timeout is reported.
module controle_medida_hcsr04 #(
    parameter int unsigned PERIODO = 12_500_000,
    parameter int unsigned TIMEOUT = 1_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       medir,
    input  logic       continuo,
    input  logic       fim_medida,
    output logic       zera,
    output logic       gera,
    output logic       registra,
    output logic       pronto,
    output logic       timeout,
    output logic       erro,
    output logic [3:0] db_estado
);

    localparam int unsigned CNT_W = 24;
    localparam logic [CNT_W-1:0] PER_MAX = CNT_W'(PERIODO - 1);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'b0000,
        PREPARACAO     = 4'b0001,
        ENVIA_TRIGGER  = 4'b0010,
        ESPERA_MEDIDA  = 4'b0011,
        ARMAZENA       = 4'b0100,
        FINAL_MEDIDA   = 4'b0101,
        ABORTA         = 4'b0110,
        ESPERA_PERIODO = 4'b0111
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             zera_q, zera_d;
    logic             gera_q, gera_d;
    logic             registra_q, registra_d;
    logic             pronto_q, pronto_d;
    logic             timeout_q, timeout_d;
    logic             erro_q, erro_d;
    logic             aborta_final_c;
`ifdef HCSR04_RETRY_EN
    logic             retry_q, retry_d;
`endif

    // State, counters and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= INICIAL;
            tmo_q      <= '0;
            per_q      <= '0;
            zera_q     <= 1'b0;
            gera_q     <= 1'b0;
            registra_q <= 1'b0;
            pronto_q   <= 1'b0;
            timeout_q  <= 1'b0;
            erro_q     <= 1'b0;
`ifdef HCSR04_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            estado_q   <= estado_d;
            tmo_q      <= tmo_d;
            per_q      <= per_d;
            zera_q     <= zera_d;
            gera_q     <= gera_d;
            registra_q <= registra_d;
            pronto_q   <= pronto_d;
            timeout_q  <= timeout_d;
            erro_q     <= erro_d;
`ifdef HCSR04_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    // Next state, counters, and outputs decoded from the next state
    always_comb begin
        estado_d = estado_q;
`ifdef HCSR04_RETRY_EN
        retry_d  = retry_q;
`endif
        case (estado_q)
            INICIAL:       if (medir || continuo) estado_d = PREPARACAO;
            PREPARACAO:    estado_d = ENVIA_TRIGGER;
            ENVIA_TRIGGER: estado_d = ESPERA_MEDIDA;
            ESPERA_MEDIDA: begin
                // fim_medida has priority over an expiring timeout
                if (fim_medida)          estado_d = ARMAZENA;
                else if (tmo_q == TMO_MAX) estado_d = ABORTA;
            end
            ARMAZENA:      estado_d = FINAL_MEDIDA;
            FINAL_MEDIDA:  estado_d = continuo ? ESPERA_PERIODO : INICIAL;
            ABORTA: begin
`ifdef HCSR04_RETRY_EN
                if (!retry_q) begin
                    retry_d  = 1'b1;
                    estado_d = PREPARACAO;
                end else begin
                    retry_d  = 1'b0;
                    estado_d = continuo ? ESPERA_PERIODO : INICIAL;
                end
`else
                estado_d = continuo ? ESPERA_PERIODO : INICIAL;
`endif
            end
            ESPERA_PERIODO: begin
                if (!continuo)             estado_d = INICIAL;
                else if (per_q == PER_MAX) estado_d = PREPARACAO;
            end
            default:       estado_d = INICIAL;
        endcase

`ifdef HCSR04_RETRY_EN
        if (estado_d == FINAL_MEDIDA) retry_d = 1'b0;
        // aborta only reports when the retry has already been spent
        aborta_final_c = (estado_d == ABORTA) && retry_d;
`else
        aborta_final_c = (estado_d == ABORTA);
`endif

        // timeout counter runs only while waiting for the echo
        tmo_d = (estado_q == ESPERA_MEDIDA) ? tmo_q + CNT_W'(1) : '0;

        // period counter restarts on a fresh measurement start, not on a retry
        if ((estado_d == PREPARACAO) &&
            ((estado_q == INICIAL) || (estado_q == ESPERA_PERIODO)))
            per_d = '0;
        else if (per_q != PER_MAX)
            per_d = per_q + CNT_W'(1);
        else
            per_d = per_q;

        zera_d     = (estado_d == PREPARACAO) || (estado_d == ABORTA);
        gera_d     = (estado_d == ENVIA_TRIGGER);
        registra_d = (estado_d == ARMAZENA);
        pronto_d   = (estado_d == FINAL_MEDIDA);
        timeout_d  = aborta_final_c;
        if (aborta_final_c)                erro_d = 1'b1;
        else if (estado_d == FINAL_MEDIDA) erro_d = 1'b0;
        else                               erro_d = erro_q;
    end

    assign zera      = zera_q;
    assign gera      = gera_q;
    assign registra  = registra_q;
    assign pronto    = pronto_q;
    assign timeout   = timeout_q;
    assign erro      = erro_q;
    assign db_estado = 4'(estado_q);

endmodule

// File: tb/tb_controle_medida_hcsr04.sv
// Testbench for controle_medida_hcsr04 (PERIODO=200, TIMEOUT=50).
module tb_controle_medida_hcsr04;

    localparam int unsigned PERIODO = 200;
    localparam int unsigned TIMEOUT = 50;
    localparam int LEN = 140;
`ifdef HCSR04_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset, medir, continuo, fim_medida;
    logic       zera, gera, registra, pronto, timeout, erro;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_fail   = 0;
    bit erro_model = 1'b0;
    logic [9:0] exp_tr [LEN];

    always #5 clock = ~clock;

    controle_medida_hcsr04 #(.PERIODO(PERIODO), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .medir(medir), .continuo(continuo),
        .fim_medida(fim_medida), .zera(zera), .gera(gera), .registra(registra),
        .pronto(pronto), .timeout(timeout), .erro(erro), .db_estado(db_estado)
    );

    function automatic logic [9:0] obs();
        return {zera, gera, registra, pronto, timeout, erro, db_estado};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Expected per-cycle trace for a single request at cycle m with an echo at f
    // (f<0: no echo), built from the event latencies of the protocol.
    task automatic build_expect(input int m, input int f);
        int st [LEN];
        bit tmo [LEN];
        int s, w, a, tries, e_set, e_clr;
        bit e;
        for (int t = 0; t < LEN; t++) begin st[t] = 0; tmo[t] = 1'b0; end
        s = m + 1; tries = 0; e_set = -1; e_clr = -1;
        for (int k = 0; k < 2; k++) begin
            st[s] = 1; st[s+1] = 2; w = s + 2;
            if (f >= w && f <= w + int'(TIMEOUT) - 1) begin
                for (int t = w; t <= f; t++) st[t] = 3;
                st[f+1] = 4; st[f+2] = 5; e_clr = f + 2;
                break;
            end
            a = w + int'(TIMEOUT);
            for (int t = w; t < a; t++) st[t] = 3;
            st[a] = 6;
            if (RETRY && tries == 0) begin tries = 1; s = a + 1; continue; end
            tmo[a] = 1'b1; e_set = a;
            break;
        end
        e = erro_model;
        for (int t = 0; t < LEN; t++) begin
            if (t == e_set) e = 1'b1;
            if (t == e_clr) e = 1'b0;
            exp_tr[t] = {(st[t] == 1 || st[t] == 6), (st[t] == 2), (st[t] == 4),
                         (st[t] == 5), tmo[t], e, 4'(st[t])};
        end
        erro_model = e;
    endtask

    // One request scenario; m2 is an extra medir pulse outside inicial (-1: none)
    task automatic run_single(input string tag, input int m, input int f, input int m2);
        build_expect(m, f);
        for (int t = 0; t < LEN; t++) begin
            @(negedge clock);
            check($sformatf("%s@%0d", tag, t), 32'(obs()), 32'(exp_tr[t]));
            medir      = (t == m) || (t == m2);
            fim_medida = (t == f);
        end
        medir = 1'b0; fim_medida = 1'b0;
    endtask

    initial begin
        int zt[$];
        int pt[$];
        int gera_at;
        int m, d, m2;

        reset = 1'b1; medir = 1'b0; continuo = 1'b0; fim_medida = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_state", 32'(obs()), 32'd0);
        reset = 1'b0;

        run_single("single", 10, 30, -1);
        run_single("timeout", 10, -1, -1);
        run_single("erro_sticky", 10, 40, 15);
        run_single("collision", 10, 10 + 3 + int'(TIMEOUT) - 1, -1);
        run_single("late_echo", 10, 10 + 3 + int'(TIMEOUT), -1);

        for (int i = 0; i < 6; i++) begin
            m  = int'($urandom_range(1, 10));
            d  = int'($urandom_range(0, TIMEOUT + 5));
            m2 = ($urandom_range(0, 1) == 1) ? m + int'($urandom_range(2, 5)) : -1;
            run_single($sformatf("rand%0d", i), m, m + 1 + d, m2);
        end

        // asynchronous reset while waiting for the echo, after a timeout
        run_single("timeout2", 5, -1, -1);
        @(negedge clock); medir = 1'b1;
        @(negedge clock); medir = 1'b0;
        repeat (6) @(negedge clock);
        check("pre_reset_state", 32'(db_estado), 32'd3);
        #2 reset = 1'b1;
        #1 check("async_reset", 32'(obs()), 32'd0);
        @(negedge clock); reset = 1'b0; erro_model = 1'b0;
        run_single("post_reset", 10, 30, -1);

        // continuous mode with echo 20 cycles after every trigger
        gera_at = -100;
        for (int t = 0; t <= 700; t++) begin
            @(negedge clock);
            if (zera) zt.push_back(t);
            if (pronto) pt.push_back(t);
            if (gera) gera_at = t;
            if (t == 700) begin
                check("cont_wait_state", 32'(db_estado), 32'd7);
                continuo = 1'b0;
            end else begin
                continuo = 1'b1;
            end
            fim_medida = (t == gera_at + 20);
        end
        fim_medida = 1'b0;
        @(negedge clock);
        check("cont_stop", 32'(obs()), 32'd0);
        check("cont_zera_count", 32'(zt.size()), 32'd4);
        check("cont_pronto_count", 32'(pt.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < zt.size())
                check($sformatf("cont_zera%0d", i), 32'(zt[i]), 32'(1 + i * int'(PERIODO)));
            if (i < pt.size() && i < zt.size())
                check($sformatf("cont_pronto%0d", i), 32'(pt[i] - zt[i]), 32'd23);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_medida_hcsr04.md
# controle_medida_hcsr04

Control unit that sequences the HC-SR04 interface datapath: it drives its clear, trigger-generate and register-enable inputs and watches its end-of-measurement flag. It supports single-shot requests and a continuous mode with a fixed measurement period. A timeout aborts measurements whose echo never completes. It sits between the application FSM (or board switches) and the sensor interface datapath.

## Interface
- PERIODO, 12_500_000: clocks between consecutive measurement starts in continuous mode (250 ms at 50 MHz); must exceed TIMEOUT+8.
- TIMEOUT, 1_500_000: maximum clocks spent waiting for fim_medida (30 ms at 50 MHz).
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state inicial and all outputs to 0.
- medir  in  1  single-shot request, level-sampled in inicial only.
- continuo  in  1  continuous mode enable.
- fim_medida  in  1  datapath end-of-measurement flag.
- zera  out  1  datapath clear.
- gera  out  1  trigger-pulse start, one cycle.
- registra  out  1  distance register enable, one cycle.
- pronto  out  1  one-cycle pulse: new distance registered.
- timeout  out  1  one-cycle pulse: measurement aborted.
- erro  out  1  sticky; set with timeout, cleared on the next pronto or reset.
- db_estado  out  4  current state encoding.

## Operation
- Moore FSM; outputs depend only on state (and the retry flag for timeout).
- States and encodings:
  - inicial (0000), all outputs 0.
  - preparacao (0001), zera=1.
  - envia_trigger (0010), gera=1.
  - espera_medida (0011).
  - armazena (0100), registra=1.
  - final_medida (0101), pronto=1.
  - aborta (0110), zera=1.
  - espera_periodo (0111).
- Transitions:
  - inicial -> preparacao if medir or continuo.
  - preparacao -> envia_trigger -> espera_medida unconditionally.
  - espera_medida -> armazena if fim_medida; else -> aborta once the timeout counter reaches TIMEOUT-1.
  - armazena -> final_medida.
  - final_medida and aborta (final) -> espera_periodo if continuo, else inicial.
  - espera_periodo -> preparacao when the period counter reaches PERIODO-1; -> inicial if continuo falls.
- Timeout counter: 24 bits; cleared on entry to espera_medida; increments each cycle there.
- Period counter: 24 bits; cleared on entry to preparacao from inicial or espera_periodo (not on retry); free-runs otherwise, saturating at PERIODO-1.
- medir asserted outside inicial is ignored, not queued.
- fim_medida and timeout expiry in the same cycle: fim_medida wins and the measurement is registered.
- reset mid-measurement: immediate return to inicial; counters and retry flag are cleared; erro is cleared.

## Timing
- medir high at cycle N in inicial:
  - zera at N+1, gera at N+2, espera_medida from N+3.
- fim_medida seen at cycle M: registra at M+1, pronto at M+2.
- No fim_medida: aborta at N+3+TIMEOUT; timeout and erro rise the same cycle.
- Continuous mode: successive zera pulses are exactly PERIODO cycles apart.
- Every pulse output is high for exactly one cycle per event.

## Configuration
- HCSR04_RETRY_EN defined:
  - The first timeout of a measurement asserts zera in aborta but not timeout.
  - It sets the retry flag and goes to preparacao for one new trigger.
  - The second timeout asserts timeout and erro, then clears the flag.
  - The flag also clears on pronto.
- HCSR04_RETRY_EN undefined:
  - Every timeout is final. The retry flag logic is absent.

## Test plan
Run with PERIODO=200, TIMEOUT=50.
- Single shot: reset, then medir=1 for 1 cycle at cycle 10, fim_medida pulse at cycle 30 -> zera@11, gera@12, registra@31, pronto@32, then db_estado=0000.
- Timeout without retry: medir at 10, no fim_medida -> timeout and erro at cycle 63, back to inicial at 64. With HCSR04_RETRY_EN: a second gera at 65, timeout at 116.
- Continuous: continuo=1 held, fim_medida returned 20 cycles after each gera -> zera pulses at 200-cycle spacing. Deasserting continuo in espera_periodo gives inicial the next cycle.
- Collision: fim_medida asserted on the cycle the timeout counter reaches 49 -> registra, no timeout, erro unchanged.
- Reset mid-operation: assert reset during espera_medida -> all outputs 0 and db_estado=0000 asynchronously. After release, medir restarts at the normal latency.
- erro stickiness: a timeout then a successful measurement -> erro high until that pronto cycle, then low.
